vector_regfile_param: RTL

- Parametrised vector register file: NREGS vector registers, each with NLANES lanes of WIDTH bits.
- Adds per-lane write masking, a second read port, same-cycle write bypass and synchronous reset of all contents.
- Adds a lane-serial load port: a valid/ready stream from the memory side fills one destination register element by element.
- A per-register busy scoreboard lets the decode stage stall on pending loads.
- Sits between decode/operand fetch and the vector ALU, with the load stream fed by the data-memory interface.

---
 rtl/vreg_pkg.sv | 26 ++
 rtl/vector_regfile_param_if.sv | 52 +++++
 rtl/vreg_load_seq.sv | 109 ++++++++++
 rtl/vector_regfile_param.sv | 97 +++++++++
 4 files changed

// File: rtl/vreg_pkg.sv
// ----------------------------------------------------------------------------
// vreg_pkg
// Shared definitions for the vector register file slice:
//   - default geometry (registers, lanes, lane width)
//   - load-sequencer state encoding
//   - lane slice helper (lane index -> bit offset in a packed vector)
// No ports.
// ----------------------------------------------------------------------------
package vreg_pkg;

    localparam int unsigned DEF_NREGS  = 4;
    localparam int unsigned DEF_NLANES = 5;
    localparam int unsigned DEF_WIDTH  = 32;

    typedef enum logic {
        LD_IDLE,
        LD_STREAM
    } ld_state_t;

    // Lane i of a packed vector lives at [lane_off(i, WIDTH) +: WIDTH].
    function automatic int unsigned lane_off(input int unsigned lane,
                                             input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/vector_regfile_param_if.sv
// ----------------------------------------------------------------------------
// vector_regfile_param_if
// Bundles the register-file bus: parallel write port, two read ports,
// lane-serial load stream and the busy scoreboard.
//   master : decode / operand fetch / memory side (drives requests)
//   slave  : the register file (drives read data, ld_ready, ld_done, busy_vec)
// ----------------------------------------------------------------------------
interface vector_regfile_param_if
    import vreg_pkg::*;
#(
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned NLANES = DEF_NLANES,
    parameter int unsigned WIDTH  = DEF_WIDTH
) ();

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned CW = $clog2(NLANES + 1);

    // Parallel write port
    logic                    we;
    logic [NLANES-1:0]       wmask;
    logic [AW-1:0]           vd;
    logic [NLANES*WIDTH-1:0] wd;
    // Read ports
    logic [AW-1:0]           va1;
    logic [AW-1:0]           va2;
    logic [NLANES*WIDTH-1:0] vr1;
    logic [NLANES*WIDTH-1:0] vr2;
    // Stream load port
    logic                    ld_start;
    logic [AW-1:0]           ld_vd;
    logic [CW-1:0]           ld_len;
    logic                    ld_valid;
    logic [WIDTH-1:0]        ld_data;
    logic                    ld_ready;
    logic                    ld_done;
    // Scoreboard
    logic [NREGS-1:0]        busy_vec;

    modport master (
        output we, wmask, vd, wd, va1, va2,
        output ld_start, ld_vd, ld_len, ld_valid, ld_data,
        input  vr1, vr2, ld_ready, ld_done, busy_vec
    );

    modport slave (
        input  we, wmask, vd, wd, va1, va2,
        input  ld_start, ld_vd, ld_len, ld_valid, ld_data,
        output vr1, vr2, ld_ready, ld_done, busy_vec
    );

endinterface

// File: rtl/vreg_load_seq.sv
// ----------------------------------------------------------------------------
// vreg_load_seq
// Lane-serial load sequencer. Accepts a load command, then takes one stream
// beat per lane into the destination register and pulses done afterwards.
//   clk, reset        : clock, synchronous active-high reset
//   ld_start_i/ld_vd_i/ld_len_i : load command (len clamped to NLANES)
//   ld_valid_i/ld_data_i/ld_ready_o : beat handshake
//   ld_done_o         : registered one-cycle completion pulse
//   busy_vec_o        : per-register pending-load scoreboard
//   lane_we_o/lane_dest_o/lane_idx_o/lane_data_o : lane write strobe to storage
// ----------------------------------------------------------------------------
module vreg_load_seq
    import vreg_pkg::*;
#(
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned NLANES = DEF_NLANES,
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned CW     = $clog2(NLANES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_start_i,
    input  logic [AW-1:0]    ld_vd_i,
    input  logic [CW-1:0]    ld_len_i,
    input  logic             ld_valid_i,
    input  logic [WIDTH-1:0] ld_data_i,
    output logic             ld_ready_o,
    output logic             ld_done_o,
    output logic [NREGS-1:0] busy_vec_o,
    output logic             lane_we_o,
    output logic [AW-1:0]    lane_dest_o,
    output logic [CW-1:0]    lane_idx_o,
    output logic [WIDTH-1:0] lane_data_o
);

    ld_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    len_q, len_d;
    logic [AW-1:0]    dest_q, dest_d;
    logic             done_q, done_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             beat;

    // Ready is a pure decode of the registered state.
    assign ld_ready_o = (state_q == LD_STREAM);
    assign beat       = ld_valid_i & ld_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        dest_d  = dest_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (ld_start_i) begin
                    if (ld_len_i != '0) begin
                        dest_d          = ld_vd_i;
                        len_d           = (ld_len_i > CW'(NLANES)) ? CW'(NLANES) : ld_len_i;
                        cnt_d           = '0;
                        busy_d[ld_vd_i] = 1'b1;
                        state_d         = LD_STREAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            LD_STREAM: begin
                if (beat) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == len_q - CW'(1)) begin
                        state_d        = LD_IDLE;
                        busy_d[dest_q] = 1'b0;
                        done_d         = 1'b1;
                    end
                end
            end
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            dest_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            dest_q  <= dest_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign ld_done_o   = done_q;
    assign busy_vec_o  = busy_q;
    assign lane_we_o   = beat;
    assign lane_dest_o = dest_q;
    assign lane_idx_o  = cnt_q;
    assign lane_data_o = ld_data_i;

endmodule

// File: rtl/vector_regfile_param.sv
// ----------------------------------------------------------------------------
// vector_regfile_param
// NREGS x NLANES x WIDTH vector register file with per-lane masked parallel
// write, two combinational read ports with same-cycle write bypass, and a
// lane-serial stream load port with busy scoreboard.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high, clears storage and load sequencer
//   bus   : vector_regfile_param_if.slave (write/read/load/scoreboard signals)
// ----------------------------------------------------------------------------
module vector_regfile_param
    import vreg_pkg::*;
#(
    parameter int unsigned NREGS  = DEF_NREGS,
    parameter int unsigned NLANES = DEF_NLANES,
    parameter int unsigned WIDTH  = DEF_WIDTH
) (
    input  logic clk,
    input  logic reset,
    vector_regfile_param_if.slave bus
);

    localparam int unsigned AW = $clog2(NREGS);
    localparam int unsigned CW = $clog2(NLANES + 1);

    logic [WIDTH-1:0]        vreg_q [NREGS][NLANES];
    logic [WIDTH-1:0]        vreg_d [NREGS][NLANES];
    logic                    ls_we;
    logic [AW-1:0]           ls_dest;
    logic [CW-1:0]           ls_idx;
    logic [WIDTH-1:0]        ls_data;
    logic [NLANES*WIDTH-1:0] rd1, rd2;

    vreg_load_seq #(
        .NREGS  (NREGS),
        .NLANES (NLANES),
        .WIDTH  (WIDTH),
        .AW     (AW),
        .CW     (CW)
    ) u_load_seq (
        .clk         (clk),
        .reset       (reset),
        .ld_start_i  (bus.ld_start),
        .ld_vd_i     (bus.ld_vd),
        .ld_len_i    (bus.ld_len),
        .ld_valid_i  (bus.ld_valid),
        .ld_data_i   (bus.ld_data),
        .ld_ready_o  (bus.ld_ready),
        .ld_done_o   (bus.ld_done),
        .busy_vec_o  (bus.busy_vec),
        .lane_we_o   (ls_we),
        .lane_dest_o (ls_dest),
        .lane_idx_o  (ls_idx),
        .lane_data_o (ls_data)
    );

    // Write merge: the stream beat is applied after the parallel write so it
    // wins a lane both target in the same cycle.
    always_comb begin
        vreg_d = vreg_q;
        for (int unsigned r = 0; r < NREGS; r++) begin
            for (int unsigned l = 0; l < NLANES; l++) begin
                if (bus.we && bus.vd == AW'(r) && bus.wmask[l])
                    vreg_d[r][l] = bus.wd[lane_off(l, WIDTH) +: WIDTH];
                if (ls_we && ls_dest == AW'(r) && ls_idx == CW'(l))
                    vreg_d[r][l] = ls_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NREGS; r++)
                for (int unsigned l = 0; l < NLANES; l++)
                    vreg_q[r][l] <= '0;
        end else begin
            vreg_q <= vreg_d;
        end
    end

    // Reads bypass only the parallel write port; stream beats show up a cycle later.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int unsigned l = 0; l < NLANES; l++) begin
            rd1[lane_off(l, WIDTH) +: WIDTH] =
                (bus.we && bus.va1 == bus.vd && bus.wmask[l]) ?
                bus.wd[lane_off(l, WIDTH) +: WIDTH] : vreg_q[bus.va1][l];
            rd2[lane_off(l, WIDTH) +: WIDTH] =
                (bus.we && bus.va2 == bus.vd && bus.wmask[l]) ?
                bus.wd[lane_off(l, WIDTH) +: WIDTH] : vreg_q[bus.va2][l];
        end
    end

    assign bus.vr1 = rd1;
    assign bus.vr2 = rd2;

endmodule
